// File: rtl/bp_table_ctrl_if.sv
// Request/grant and prediction signals between fetch/execute and the
// branch-direction predictor table controller.
`timescale 1ns/1ps
interface bp_table_ctrl_if #(
  parameter int unsigned IDX_BITS = 6
);
  logic                lookup_valid;
  logic [IDX_BITS-1:0] lookup_idx;
  logic                lookup_ready;
  logic                pred_valid;
  logic                pred_taken;
  logic [1:0]          pred_state;
  logic                update_valid;
  logic [IDX_BITS-1:0] update_idx;
  logic                update_taken;
  logic                update_ready;
  logic                flush_req;
  logic                init_busy;

  // Pipeline side: issues lookups, updates and flushes.
  modport master (
    output lookup_valid, lookup_idx, update_valid, update_idx, update_taken, flush_req,
    input  lookup_ready, pred_valid, pred_taken, pred_state, update_ready, init_busy
  );

  // Table controller side.
  modport slave (
    input  lookup_valid, lookup_idx, update_valid, update_idx, update_taken, flush_req,
    output lookup_ready, pred_valid, pred_taken, pred_state, update_ready, init_busy
  );
endinterface

// File: rtl/bp_table_ctrl.sv
// Branch-direction predictor table: 2-bit saturating counters, a single
// access slot per cycle shared by lookups and training updates.
`timescale 1ns/1ps
module bp_table_ctrl #(
  parameter int unsigned IDX_BITS   = 6,
  parameter logic [1:0]  INIT_STATE = 2'b01
) (
  input  logic             clock,
  input  logic             reset,
  bp_table_ctrl_if.slave   bus
);

  localparam int unsigned         DEPTH    = 2 ** IDX_BITS;
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(DEPTH - 1);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  typedef enum logic {
    PRIO_UPD,
    PRIO_LKP
  } prio_e;

  state_e              state_q, state_d;
  prio_e               prio_q, prio_d;
  logic [IDX_BITS-1:0] init_idx_q, init_idx_d;

  logic                lookup_grant;
  logic                update_grant;

  logic                tbl_we;
  logic [IDX_BITS-1:0] tbl_widx;
  logic [1:0]          tbl_wdata;
  logic [1:0]          tbl_q [DEPTH];

  logic                pred_valid_q;
  logic [1:0]          pred_state_q;

  // Saturating 2-bit counter step toward the resolved direction.
  function automatic logic [1:0] sat_next(input logic [1:0] cur, input logic taken);
    logic [1:0] nxt;
    nxt = cur;
    if (taken) begin
      if (cur != 2'b11) nxt = cur + 2'b01;
    end else begin
      if (cur != 2'b00) nxt = cur - 2'b01;
    end
    return nxt;
  endfunction

  // State, walk index and arbitration priority.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_INIT;
      init_idx_q <= '0;
      prio_q     <= PRIO_UPD;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      prio_q     <= prio_d;
    end
  end

  // Next-state, arbitration and table write port selection.
  always_comb begin
    state_d      = state_q;
    init_idx_d   = init_idx_q;
    prio_d       = prio_q;
    lookup_grant = 1'b0;
    update_grant = 1'b0;
    tbl_we       = 1'b0;
    tbl_widx     = '0;
    tbl_wdata    = '0;

    unique case (state_q)
      ST_INIT: begin
        tbl_we    = 1'b1;
        tbl_widx  = init_idx_q;
        tbl_wdata = INIT_STATE;
        if (bus.flush_req) begin
          init_idx_d = '0;
        end else if (init_idx_q == LAST_IDX) begin
          state_d    = ST_RUN;
          init_idx_d = '0;
          prio_d     = PRIO_UPD;
        end else begin
          init_idx_d = init_idx_q + IDX_BITS'(1);
        end
      end

      ST_RUN: begin
        if (bus.flush_req) begin
          // A flush wins the slot outright; nobody is granted this cycle.
          state_d    = ST_INIT;
          init_idx_d = '0;
        end else if (bus.lookup_valid && bus.update_valid) begin
          if (prio_q == PRIO_UPD) begin
            update_grant = 1'b1;
            prio_d       = PRIO_LKP;
          end else begin
            lookup_grant = 1'b1;
            prio_d       = PRIO_UPD;
          end
        end else begin
          lookup_grant = bus.lookup_valid;
          update_grant = bus.update_valid;
        end

        if (update_grant) begin
          tbl_we    = 1'b1;
          tbl_widx  = bus.update_idx;
          tbl_wdata = sat_next(tbl_q[bus.update_idx], bus.update_taken);
        end
      end

      default: begin
        state_d    = ST_INIT;
        init_idx_d = '0;
      end
    endcase
  end

  // Counter storage; contents are undefined until the first walk completes.
  always_ff @(posedge clock) begin
    if (tbl_we) tbl_q[tbl_widx] <= tbl_wdata;
  end

  // Prediction register, loaded only on a lookup grant.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pred_valid_q <= 1'b0;
      pred_state_q <= 2'b00;
    end else begin
      pred_valid_q <= lookup_grant;
      if (lookup_grant) pred_state_q <= tbl_q[bus.lookup_idx];
    end
  end

  assign bus.lookup_ready = lookup_grant;
  assign bus.update_ready = update_grant;
  assign bus.init_busy    = (state_q == ST_INIT);
  assign bus.pred_valid   = pred_valid_q;
  assign bus.pred_state   = pred_state_q;
  assign bus.pred_taken   = pred_state_q[1];

endmodule

// File: tb/tb_bp_table_ctrl.sv
// Self-checking bench for bp_table_ctrl against a behavioural table model.
`timescale 1ns/1ps
module tb_bp_table_ctrl;

  localparam int unsigned IDX_BITS = 6;
  localparam int unsigned DEPTH    = 64;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  bp_table_ctrl_if #(.IDX_BITS(IDX_BITS)) bus ();

  bp_table_ctrl #(.IDX_BITS(IDX_BITS), .INIT_STATE(2'b01)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: remaining init cycles, next contested winner, counters.
  int         init_left;
  bit         prio_upd;
  bit         exp_pv;
  logic [1:0] exp_ps;
  int         tbl [DEPTH];

  logic [6:0] exp_vec, obs_vec;
  logic       obs_lr, obs_ur, obs_busy, obs_pv, obs_pt;
  logic [1:0] obs_ps;

  task automatic model_reset();
    init_left = DEPTH;
    prio_upd  = 1'b1;
    exp_pv    = 1'b0;
    exp_ps    = 2'b00;
  endtask

  // Drive one cycle, sample at negedge, then advance the model past the edge.
  task automatic step(input bit lv, input int unsigned li, input bit uv,
                      input int unsigned ui, input bit ut, input bit fl);
    bit busy, g_l, g_u;
    bus.lookup_valid = lv;
    bus.lookup_idx   = IDX_BITS'(li);
    bus.update_valid = uv;
    bus.update_idx   = IDX_BITS'(ui);
    bus.update_taken = ut;
    bus.flush_req    = fl;
    busy = (init_left > 0);
    g_l  = 1'b0;
    g_u  = 1'b0;
    if (!busy && !fl) begin
      if (lv && uv) begin
        if (prio_upd) g_u = 1'b1; else g_l = 1'b1;
      end else begin
        g_l = lv;
        g_u = uv;
      end
    end
    exp_vec = {busy, g_l, g_u, exp_pv, exp_pv ? exp_ps : 2'b00, exp_pv ? exp_ps[1] : 1'b0};
    @(negedge clock);
    obs_lr   = bus.lookup_ready;
    obs_ur   = bus.update_ready;
    obs_busy = bus.init_busy;
    obs_pv   = bus.pred_valid;
    obs_ps   = bus.pred_state;
    obs_pt   = bus.pred_taken;
    obs_vec  = {obs_busy, obs_lr, obs_ur, obs_pv, exp_pv ? obs_ps : 2'b00, exp_pv ? obs_pt : 1'b0};
    @(posedge clock);
    #1;
    exp_pv = g_l;
    if (g_l) exp_ps = 2'(tbl[li]);
    if (g_u) tbl[ui] = ut ? ((tbl[ui] < 3) ? tbl[ui] + 1 : 3) : ((tbl[ui] > 0) ? tbl[ui] - 1 : 0);
    if (lv && uv && (g_l || g_u)) prio_upd = !prio_upd;
    if (busy) begin
      if (fl) init_left = DEPTH;
      else begin
        init_left--;
        if (init_left == 0) begin
          foreach (tbl[i]) tbl[i] = 1;
          prio_upd = 1'b1;
        end
      end
    end else if (fl) begin
      init_left = DEPTH;
    end
  endtask

  task automatic test_reset();
    int busy_cnt;
    bus.lookup_valid = 0; bus.lookup_idx = '0; bus.update_valid = 0;
    bus.update_idx = '0; bus.update_taken = 0; bus.flush_req = 0;
    reset = 1'b0;
    #2;
    n_checks++;
    if ({bus.init_busy, bus.lookup_ready, bus.update_ready, bus.pred_valid, bus.pred_state, bus.pred_taken} !== 7'b1000000) begin
      n_fail++;
      $display("FAIL reset_values: got %b want %b", {bus.init_busy, bus.lookup_ready, bus.update_ready,
               bus.pred_valid, bus.pred_state, bus.pred_taken}, 7'b1000000);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    model_reset();
    busy_cnt = 0;
    for (int i = 0; i < 70; i++) begin
      step(0, 0, 0, 0, 0, 0);
      busy_cnt += int'(obs_busy);
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL reset_init cyc %0d: got %b want %b", i, obs_vec, exp_vec);
      end
    end
    n_checks++;
    if (busy_cnt !== 64) begin
      n_fail++;
      $display("FAIL reset_busy_len: got %0d want 64", busy_cnt);
    end
    for (int k = 0; k < 3; k++) begin
      int unsigned idx;
      idx = (k == 0) ? 0 : (k == 1) ? 37 : 63;
      step(1, idx, 0, 0, 0, 0);
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL init_lookup_grant idx %0d: got %b want %b", idx, obs_vec, exp_vec);
      end
      step(0, 0, 0, 0, 0, 0);
      n_checks++;
      if ({obs_pv, obs_ps, obs_pt} !== 4'b1010) begin
        n_fail++;
        $display("FAIL init_lookup_value idx %0d: got %b want %b", idx, {obs_pv, obs_ps, obs_pt}, 4'b1010);
      end
    end
  endtask

  task automatic test_saturation();
    int ups [3] = '{3, 2, 4};
    logic [3:0] want [3] = '{4'b1111, 4'b1010, 4'b1000};
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < ups[ph]; i++) begin
        step(0, 0, 1, 5, (ph == 0), 0);
        n_checks++;
        if (obs_vec !== exp_vec) begin
          n_fail++;
          $display("FAIL sat_update ph %0d: got %b want %b", ph, obs_vec, exp_vec);
        end
      end
      step(1, 5, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      n_checks++;
      if ({obs_pv, obs_ps, obs_pt} !== want[ph]) begin
        n_fail++;
        $display("FAIL sat_value ph %0d: got %b want %b", ph, {obs_pv, obs_ps, obs_pt}, want[ph]);
      end
    end
  endtask

  task automatic run_flush_init(input string name);
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 64; i++) begin
      step(0, 0, 0, 0, 0, 0);
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL %s cyc %0d: got %b want %b", name, i, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_contention();
    run_flush_init("cont_init");
    for (int k = 0; k < 4; k++) begin
      step(1, k, 1, 10 + k, 1, 0);
      n_checks++;
      if ({obs_ur, obs_lr} !== ((k % 2 == 0) ? 2'b10 : 2'b01) || obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL contention cyc %0d: got ur/lr %b%b want %b", k, obs_ur, obs_lr,
                 (k % 2 == 0) ? 2'b10 : 2'b01);
      end
    end
    step(1, 3, 0, 0, 0, 0);
    step(1, 4, 1, 11, 0, 0);
    n_checks++;
    if ({obs_ur, obs_lr} !== 2'b10) begin
      n_fail++;
      $display("FAIL prio_uncontested: got ur/lr %b%b want 10", obs_ur, obs_lr);
    end
  endtask

  task automatic test_flush_run();
    int busy_cnt;
    for (int i = 0; i < 3; i++) step(0, 0, 1, 9, 1, 0);
    step(1, 9, 1, 9, 0, 1);
    n_checks++;
    if ({obs_lr, obs_ur, obs_busy} !== 3'b000 || obs_vec !== exp_vec) begin
      n_fail++;
      $display("FAIL flush_grant_block: got lr/ur/busy %b%b%b want 000", obs_lr, obs_ur, obs_busy);
    end
    busy_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      step(1, 9, 0, 0, 0, 0);
      busy_cnt += int'(obs_busy);
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL flush_run_init cyc %0d: got %b want %b", i, obs_vec, exp_vec);
      end
    end
    n_checks++;
    if (busy_cnt !== 64) begin
      n_fail++;
      $display("FAIL flush_busy_len: got %0d want 64", busy_cnt);
    end
    step(1, 9, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    n_checks++;
    if ({obs_pv, obs_ps, obs_pt} !== 4'b1010) begin
      n_fail++;
      $display("FAIL flush_idx9_value: got %b want 1010", {obs_pv, obs_ps, obs_pt});
    end
  endtask

  task automatic test_flush_in_init();
    int cnt;
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 30; i++) step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      step(0, 0, 0, 0, 0, 0);
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL restart_init cyc %0d: got %b want %b", i, obs_vec, exp_vec);
      end
      if (!obs_busy) break;
      cnt++;
    end
    n_checks++;
    if (cnt !== 64) begin
      n_fail++;
      $display("FAIL restart_busy_len: got %0d want 64", cnt);
    end
    for (int i = 0; i <= 64; i++) begin
      step(i < 64, i, 0, 0, 0, 0);
      if (i > 0) begin
        n_checks++;
        if ({obs_pv, obs_ps} !== 3'b101) begin
          n_fail++;
          $display("FAIL restart_entry %0d: got %b want 101", i - 1, {obs_pv, obs_ps});
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int busy_cnt;
    step(0, 0, 1, 20, 1, 0);
    step(0, 0, 1, 20, 1, 0);
    step(1, 20, 0, 0, 0, 0);
    n_checks++;
    if (bus.pred_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_pred_valid: got %b want 1", bus.pred_valid);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({bus.pred_valid, bus.init_busy, bus.lookup_ready, bus.update_ready} !== 4'b0100) begin
      n_fail++;
      $display("FAIL mid_reset_drop: got %b want 0100",
               {bus.pred_valid, bus.init_busy, bus.lookup_ready, bus.update_ready});
    end
    @(posedge clock); #1;
    reset = 1'b1;
    model_reset();
    busy_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      step(0, 0, 0, 0, 0, 0);
      busy_cnt += int'(obs_busy);
    end
    n_checks++;
    if (busy_cnt !== 64) begin
      n_fail++;
      $display("FAIL mid_reset_busy_len: got %0d want 64", busy_cnt);
    end
    step(1, 20, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    n_checks++;
    if ({obs_pv, obs_ps, obs_pt} !== 4'b1010) begin
      n_fail++;
      $display("FAIL mid_reset_idx20: got %b want 1010", {obs_pv, obs_ps, obs_pt});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), $urandom_range(0, 63), 1'($urandom_range(0, 1)),
           $urandom_range(0, 63), 1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0));
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %b want %b", i, obs_vec, exp_vec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_saturation();
    test_contention();
    test_flush_run();
    test_flush_in_init();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_table_ctrl.md
Name: bp_table_ctrl

Overview:
- Controller and arbiter for the branch-direction predictor table: an array of 2^IDX_BITS two-bit saturating counters.
- The table has a single access slot per cycle. Fetch-stage lookups and execute-stage training updates compete for that slot.
- Sequences table initialisation after reset and on pipeline flush requests.

Parameters:
- IDX_BITS, 6, table index width; table depth = 2^IDX_BITS entries.
- INIT_STATE, 2'b01, counter value written to every entry during initialisation (weakly not taken).

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- lookup_valid  in  1  fetch requests a prediction.
- lookup_idx  in  IDX_BITS  table index for the lookup.
- lookup_ready  out  1  lookup granted this cycle.
- pred_valid  out  1  pred_taken/pred_state valid this cycle.
- pred_taken  out  1  predicted direction (counter MSB).
- pred_state  out  2  raw counter value read.
- update_valid  in  1  execute reports a resolved branch.
- update_idx  in  IDX_BITS  table index to train.
- update_taken  in  1  resolved direction.
- update_ready  out  1  update granted this cycle.
- flush_req  in  1  single-cycle pulse; re-initialise the table.
- init_busy  out  1  initialisation in progress.

Behaviour:
- Storage is a flop array inside the block, one counter per entry. Reads are combinational within the block; writes occur at the clock edge.
- FSM states and transitions:
  - INIT: walks init_idx from 0 to 2^IDX_BITS-1, writing INIT_STATE to one entry per cycle. After writing the last index, moves to RUN on the next edge.
  - RUN: normal operation. flush_req moves to INIT with init_idx=0 on the next edge.
- While reset is asserted:
  - state=INIT, init_idx=0, prio=UPD.
  - init_busy=1; lookup_ready=0, update_ready=0; pred_valid=0, pred_taken=0, pred_state=0.
  - Table contents are don't-care until INIT completes.
- init_busy is 1 exactly when state==INIT. Releasing reset gives 2^IDX_BITS cycles with init_busy=1.
- During INIT:
  - lookup_ready=0 and update_ready=0, regardless of valids.
  - Requesters hold valid and payload until they are granted.
- flush_req during INIT restarts the walk: init_idx=0 on the next edge.
- Arbitration in RUN (ready outputs are combinational):
  - Only one valid: that requester is granted.
  - Both valid: prio selects the winner, then prio toggles.
  - prio changes only on contested cycles.
  - prio resets to UPD on reset and on every INIT->RUN transition.
- flush_req in RUN blocks grants that cycle: both readies=0. No table write occurs that cycle.
- Lookup:
  - Granted at edge N: pred_valid=1 in cycle N+1, with pred_state = table[lookup_idx] as sampled at edge N, and pred_taken = pred_state[1].
  - pred_valid=0 in any cycle that does not follow a lookup grant.
  - Predictions stay registered (no hold): a new lookup grant overwrites them.
- Update is a read-modify-write in the granted cycle:
  - update_taken=1: counter increments, saturating at 3.
  - update_taken=0: counter decrements, saturating at 0.
  - The new value is visible to a lookup granted in the following cycle.
- Lookup and update are never granted in the same cycle, so there is no same-cycle index hazard.
- Reset asserted mid-INIT or mid-RUN aborts immediately. Any pred_valid in flight is dropped.

Test Plan:
- Reset release, no requests -> init_busy=1 for exactly 64 cycles. Readies stay 0. Then init_busy=0. Lookups of idx 0, 37 and 63 return pred_state=2'b01, pred_taken=0, with pred_valid one cycle after grant.
- Three update_taken=1 to idx 5, then lookup idx 5 -> pred_state=2'b11, pred_taken=1. Two update_taken=0, then lookup -> 2'b01, pred_taken=0. Four more not-taken updates, then lookup -> 2'b00 (saturates, no wrap).
- lookup_valid and update_valid held high together for 4 cycles after INIT -> grant order: update, lookup, update, lookup. prio changes only on these contested cycles.
- Train idx 9 to 2'b11, pulse flush_req in RUN -> both readies 0 that cycle, init_busy=1 for 64 cycles. Lookup idx 9 afterwards -> 2'b01.
- flush_req pulsed at INIT cycle 30 -> init_busy stays high for 64 further cycles from the restart. All entries read 2'b01.
- reset asserted one cycle after a lookup grant -> pred_valid=0 immediately. After release, INIT runs from index 0.
